// File: rtl/sign_mag_pkg.sv
// Shared types for the frame sign-magnitude accumulator: FSM state encoding
// and the count-width rule used to size the per-frame sample counter.
package sign_mag_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   // Counter must be able to hold FRAME_LEN itself, not just FRAME_LEN-1.
   function automatic int cnt_width(input int frame_len);
      return $clog2(frame_len + 1);
   endfunction

   localparam int DEF_FRAME_LEN = 16;
   localparam int DEF_CNT_W     = cnt_width(DEF_FRAME_LEN);

endpackage

// File: rtl/sign_mag_add_core.sv
// Combinational sign-magnitude add: accumulator plus zero-extended sample,
// with carry out of the magnitude field and canonical +0 on zero results.
module sign_mag_add_core #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 12
) (
   input  logic [ACC_WIDTH-1:0]  acc_i,
   input  logic [DATA_WIDTH-1:0] smp_i,
   output logic [ACC_WIDTH-1:0]  sum_o,
   output logic                  carry_o
);

   localparam int MAG_W = ACC_WIDTH - 1;

   logic [MAG_W-1:0] a_mag;
   logic [MAG_W-1:0] b_mag;
   logic [MAG_W-1:0] r_mag;
   logic [MAG_W:0]   mag_sum;
   logic             a_sgn;
   logic             b_sgn;
   logic             r_sgn;

   always_comb begin
      a_mag = acc_i[MAG_W-1:0];
      b_mag = '0;
      b_mag[DATA_WIDTH-2:0] = smp_i[DATA_WIDTH-2:0];
      // A negative zero on either operand is treated as positive zero.
      a_sgn   = acc_i[ACC_WIDTH-1] && (a_mag != '0);
      b_sgn   = smp_i[DATA_WIDTH-1] && (b_mag != '0);
      mag_sum = {1'b0, a_mag} + {1'b0, b_mag};
      carry_o = 1'b0;
      if (a_sgn == b_sgn) begin
         r_mag   = mag_sum[MAG_W-1:0];
         r_sgn   = a_sgn;
         carry_o = mag_sum[MAG_W];
      end else if (a_mag >= b_mag) begin
         r_mag = a_mag - b_mag;
         r_sgn = a_sgn;
      end else begin
         r_mag = b_mag - a_mag;
         r_sgn = b_sgn;
      end
      if (r_mag == '0) begin
         r_sgn = 1'b0;
      end
      sum_o = {r_sgn, r_mag};
   end

endmodule

// File: rtl/sign_mag_accum.sv
// Frame accumulator: sums FRAME_LEN sign-magnitude samples, then offers the
// result on a valid/ready handshake. SIGN_MAG_ACC_SAT_EN selects saturation.
//
// state | meaning
// ACCUM | accepting samples, in_ready=1
// DONE  | frame result held, out_valid=1, waits for out_ready
module sign_mag_accum
   import sign_mag_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 12,
   parameter int FRAME_LEN  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr_in,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          a_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_WIDTH-1:0]           sum_out,
   output logic                           ovf_out,
   output logic [$clog2(FRAME_LEN+1)-1:0] cnt_out
);

   localparam int               CNT_W    = cnt_width(FRAME_LEN);
   localparam int               MAG_W    = ACC_WIDTH - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [ACC_WIDTH-1:0] add_sum;
   logic [ACC_WIDTH-1:0] add_res;
   logic                 add_carry;

   sign_mag_add_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_add (
      .acc_i   (sum_q),
      .smp_i   (a_in),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

`ifdef SIGN_MAG_ACC_SAT_EN
   // Clamp keeps the sign; later opposite-sign samples subtract from full scale.
   assign add_res = add_carry ? {add_sum[ACC_WIDTH-1], {MAG_W{1'b1}}} : add_sum;
`else
   assign add_res = add_sum;
`endif

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (clr_in) begin
         state_d = ACCUM;
         sum_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  sum_d = add_res;
                  ovf_d = ovf_q | add_carry;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  sum_d   = '0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign sum_out   = sum_q;
   assign ovf_out   = ovf_q;
   assign cnt_out   = cnt_q;

endmodule

// File: tb/tb_sign_mag_accum.sv
// Scoreboard bench for sign_mag_accum: frame results queued at stimulus time
// and popped by a monitor on each result handshake.
module tb_sign_mag_accum;

   localparam int DW  = 8;
   localparam int AW  = 12;
   localparam int FL  = 4;
   localparam int CW  = $clog2(FL + 1);
   localparam int AW2 = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_in = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] a_in = '0;
   logic          in_ready, out_valid, ovf_out;
   logic [AW-1:0] sum_out;
   logic [CW-1:0] cnt_out;

   logic           clr2 = 1'b0;
   logic           in_valid2 = 1'b0;
   logic           out_ready2 = 1'b0;
   logic [DW-1:0]  a_in2 = '0;
   logic           in_ready2, out_valid2, ovf_out2;
   logic [AW2-1:0] sum_out2;
   logic [CW-1:0]  cnt_out2;

   sign_mag_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .clr_in(clr_in), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
      .ovf_out(ovf_out), .cnt_out(cnt_out));

   sign_mag_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(AW2), .FRAME_LEN(FL)) dut2 (
      .clk(clk), .rst(rst), .clr_in(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
      .a_in(a_in2), .out_valid(out_valid2), .out_ready(out_ready2), .sum_out(sum_out2),
      .ovf_out(ovf_out2), .cnt_out(cnt_out2));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] sum;
      logic          ovf;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got sum 0x%0h with nothing expected", sum_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_sum", 32'(sum_out), 32'(e.sum));
            check("res_ovf", 32'(ovf_out), 32'(e.ovf));
            check("res_cnt", 32'(cnt_out), 32'(e.cnt));
         end
      end
   end

   // Inputs change 1 time unit after the rising edge; returns at the same phase.
   task automatic send(input logic [DW-1:0] s);
      in_valid = 1'b1;
      a_in     = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                             input logic [DW-1:0] s2, input logic [DW-1:0] s3);
      send(s0);
      check("cnt_after_1", 32'(cnt_out), 1);
      send(s1);
      send(s2);
      send(s3);
      check("valid_at_last_accept", 32'(out_valid), 1);
      check("cnt_in_done", 32'(cnt_out), FL);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("ready_after_hs", 32'(in_ready), 1);
      check("sum_clr_after_hs", 32'(sum_out), 0);
   endtask

   task automatic frame2(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                         input logic [DW-1:0] s2, input logic [DW-1:0] s3,
                         input logic [AW2-1:0] exp_sum, input string name);
      logic [DW-1:0] s [4];
      s = '{s0, s1, s2, s3};
      for (int i = 0; i < 4; i++) begin
         in_valid2 = 1'b1;
         a_in2     = s[i];
         @(posedge clk);
         #1;
      end
      in_valid2 = 1'b0;
      check({name, "_valid"}, 32'(out_valid2), 1);
      check({name, "_sum"}, 32'(sum_out2), 32'(exp_sum));
      check({name, "_ovf"}, 32'(ovf_out2), 1);
      out_ready2 = 1'b1;
      @(posedge clk);
      #1;
      out_ready2 = 1'b0;
      check({name, "_cleared"}, 32'(sum_out2), 0);
   endtask

   initial begin
      #2;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_ready", 32'(in_ready), 1);
      check("rst_sum", 32'(sum_out), 0);
      check("rst_ovf", 32'(ovf_out), 0);
      check("rst_cnt", 32'(cnt_out), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 5 + 3 - 2 - 1 = +5
      exp_q.push_back('{sum: 12'h005, ovf: 1'b0, cnt: CW'(FL)});
      send_frame(8'h05, 8'h03, 8'h82, 8'h81);
      handshake();

      // +5 -5 gives +0; -0 input acts as +0
      exp_q.push_back('{sum: 12'h000, ovf: 1'b0, cnt: CW'(FL)});
      send(8'h05);
      send(8'h85);
      check("cancel_pos_zero", 32'(sum_out), 0);
      send(8'h00);
      send(8'h80);
      check("neg_zero_in", 32'(sum_out), 0);
      handshake();

      // 127 + 1 - 5 + 2 = 125; then held in DONE with in_valid asserted
      exp_q.push_back('{sum: 12'h07D, ovf: 1'b0, cnt: CW'(FL)});
      send_frame(8'h7F, 8'h01, 8'h85, 8'h02);
      in_valid = 1'b1;
      a_in     = 8'h11;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_ready_low", 32'(in_ready), 0);
         check("hold_sum", 32'(sum_out), 'h07D);
         check("hold_cnt", 32'(cnt_out), FL);
      end
      in_valid = 1'b0;
      handshake();

      // clr together with a sample drops the sample and restarts the frame
      send(8'h10);
      send(8'h20);
      check("pre_clr_sum", 32'(sum_out), 'h030);
      clr_in   = 1'b1;
      in_valid = 1'b1;
      a_in     = 8'h44;
      @(posedge clk);
      #1;
      clr_in   = 1'b0;
      in_valid = 1'b0;
      check("clr_sum", 32'(sum_out), 0);
      check("clr_cnt", 32'(cnt_out), 0);
      exp_q.push_back('{sum: 12'h002, ovf: 1'b0, cnt: CW'(FL)});
      send_frame(8'h01, 8'h02, 8'h03, 8'h84);
      handshake();

      // clr in DONE discards the pending result
      send_frame(8'h01, 8'h01, 8'h01, 8'h01);
      clr_in = 1'b1;
      @(posedge clk);
      #1;
      clr_in = 1'b0;
      check("clr_done_valid", 32'(out_valid), 0);
      check("clr_done_sum", 32'(sum_out), 0);

      // four -1 samples give -4; async reset while the result is pending
      send_frame(8'h81, 8'h81, 8'h81, 8'h81);
      check("neg_sum", 32'(sum_out), 'h804);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_sum", 32'(sum_out), 0);
      check("arst_ovf", 32'(ovf_out), 0);
      check("arst_cnt", 32'(cnt_out), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef SIGN_MAG_ACC_SAT_EN
      frame2(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, "ovf_pos");
      frame2(8'h7F, 8'h7F, 8'h81, 8'h00, 8'h7E, "ovf_sub");
      frame2(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, "ovf_neg");
`else
      frame2(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7C, "ovf_pos");
      frame2(8'h7F, 8'h7F, 8'h81, 8'h00, 8'h7D, "ovf_sub");
      frame2(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, "ovf_neg");
`endif

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sign_mag_accum.md
# sign_mag_accum

Frame-based sign-magnitude accumulator: sums FRAME_LEN sign-magnitude samples into a wider sign-magnitude accumulator, then presents the frame result under a valid/ready handshake. It is the next generation of the team's combinational sign-magnitude adder, generalised in operand and accumulator width and frame length. It adds overflow detection, optional saturation, and canonical positive zero. It sits between a sample source (ROM or stream) and a consumer that takes one result per frame.

## Interface
- DATA_WIDTH, 8: sample width; MSB is the sign, the rest is the magnitude.
- ACC_WIDTH, 12: accumulator width; MSB is the sign. Must be ≥ DATA_WIDTH.
- FRAME_LEN, 16: samples per frame, ≥ 1.
- clk  in  1  rising-edge clock; the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- clr_in  in  1  synchronous frame abort/clear.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- a_in  in  DATA_WIDTH  sign-magnitude sample.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  ACC_WIDTH  accumulator, sign-magnitude.
- ovf_out  out  1  sticky overflow flag for the current frame.
- cnt_out  out  $clog2(FRAME_LEN+1)  samples accepted in the current frame.

## Operation
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset: state ACCUM; sum_out=0, ovf_out=0, cnt_out=0.
- ACCUM, on accept:
  - sum_out ← sum_out ⊕ a_in, where ⊕ is the sign-magnitude add below.
  - cnt_out increments.
  - If cnt_out == FRAME_LEN-1, the next state is DONE. cnt_out reads FRAME_LEN in DONE.
- DONE: on out_ready, the next state is ACCUM, and sum_out, ovf_out and cnt_out clear to 0. in_valid is ignored in DONE.
- Sign-magnitude add:
  - Zero-extend the sample magnitude to ACC_WIDTH-1 bits.
  - Equal signs: add the magnitudes; the sign is unchanged.
  - Different signs: subtract the smaller magnitude from the larger; the sign is that of the larger.
  - Equal magnitudes with different signs give a result of +0.
  - Any zero-magnitude result has sign 0. A -0 input behaves as +0.
- Overflow: a carry out of the ACC_WIDTH-1 magnitude bits sets ovf_out. ovf_out stays set until the frame ends or is cleared.
- clr_in priority is below rst and above all other inputs. It applies in any state:
  - Next state ACCUM; sum_out, ovf_out and cnt_out go to 0.
  - A sample presented in the same cycle is dropped.
  - A result pending in DONE is discarded.

## Timing
- All outputs are registered, except in_ready and out_valid, which decode directly from the state register.
- The sample is accepted at edge k; sum_out and cnt_out update at edge k.
- The last sample is accepted at edge k; out_valid is high from edge k.
- The result holds stable while out_valid && !out_ready.
- Minimum frame period is FRAME_LEN+1 cycles: FRAME_LEN accept cycles plus one DONE cycle with out_ready=1.
- rst asserted mid-frame or in DONE clears all state and outputs immediately, without waiting for a clock edge.

## Configuration
- SIGN_MAG_ACC_SAT_EN defined:
  - On overflow, the magnitude clamps to all-ones and the sign is kept.
  - ovf_out is set.
  - Further same-sign samples stay clamped; opposite-sign samples subtract from the clamped value.
- SIGN_MAG_ACC_SAT_EN undefined:
  - On overflow, the magnitude wraps modulo 2^(ACC_WIDTH-1) and the sign is kept.
  - ovf_out is set.

## Structure
- Package sign_mag_pkg holds:
  - the typedef enum logic {ACCUM, DONE} for the FSM state;
  - the localparam pattern for the count width.
- Sub-module sign_mag_add_core: a combinational, parametrised sign-magnitude add with carry-out and zero normalisation. The instance inside sign_mag_accum performs the add.
- The FSM, counter, sticky flag and saturation mux live in sign_mag_accum.

## Test plan
- DATA_WIDTH=8, ACC_WIDTH=12, FRAME_LEN=4. Input 0x05, 0x03, 0x82, 0x81 → sum_out=0x005, ovf_out=0, cnt_out=4. out_valid goes high at the 4th accept edge.
- Same parameters. Input 0x05, 0x85, 0x00, 0x80 → sum_out=0x000 (not 0x800).
- ACC_WIDTH=8, FRAME_LEN=4. Input four samples of 0x7F:
  - Without the macro: sum_out=0x7C, ovf_out=1.
  - With SIGN_MAG_ACC_SAT_EN: sum_out=0x7F, ovf_out=1.
- In DONE, hold out_ready=0 for 5 cycles while driving in_valid=1 → in_ready=0; sum_out and cnt_out stay stable. Then pulse out_ready → state ACCUM next cycle with sum_out=0.
- After 2 accepted samples, pulse clr_in together with in_valid → sum_out=0, cnt_out=0, the sample is dropped. The next 4 samples form a complete frame.
- Assert rst asynchronously, mid-cycle, while in DONE → out_valid=0, sum_out=0, ovf_out=0, cnt_out=0 before the next clock edge.
